muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter W, default 32, operand and HI/LO width; all other requirements are stated for W=32.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 2, operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-006 SHALL have ports a and b, input, 32 each, operands; divisor is b.
REQ-007 SHALL have ports mthi and mtlo, input, 1 each, direct write strobes for HI and LO.
REQ-008 SHALL have port wdata, input, 32, data for mthi and mtlo.
REQ-009 SHALL have port busy, output, 1, operation in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse marking the result.
REQ-011 SHALL have ports hi and lo, output, 32 each, architectural HI and LO registers.
REQ-012 SHALL have port div_by_zero, output, 1, asserted with done when a DIV/DIVU had b=0.

Function
REQ-013 SHALL implement FSM IDLE -> RUN (32 cycles, one bit per cycle) -> SIGN (1 cycle) -> IDLE.
REQ-014 SHALL, when start=1 in IDLE at edge N, latch op, a and b, hold busy=1 for cycles N+1..N+33, and present the new hi/lo with done=1 for exactly cycle N+34, when busy=0.
REQ-015 SHALL use fixed latency for all ops and operand values, with no early termination.
REQ-016 SHALL compute MULT/MULTU as a 64-bit product, hi=[63:32] and lo=[31:0]; MULT uses operand magnitudes and negates the product in SIGN when the operand signs differ.
REQ-017 SHALL compute DIV/DIVU by restoring division: lo=quotient, truncated toward zero; hi=remainder, with the sign of the dividend.
REQ-018 SHALL, for signed DIV of 0x80000000 by 0xFFFFFFFF, give lo=0x80000000 and hi=0, with no flag.
REQ-019 SHALL, for b=0 on DIV/DIVU, run the full latency, leave hi and lo unchanged, and pulse div_by_zero together with done.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL, when mthi/mtlo=1 in IDLE, write wdata to HI/LO at that edge; mthi and mtlo in the same cycle both write.
REQ-022 SHALL ignore mthi/mtlo while busy=1.
REQ-023 SHALL, when start and mthi/mtlo coincide in IDLE, apply the write immediately; the later op result then overwrites it.
REQ-024 SHALL keep hi and lo stable except on a completion, a direct write, or reset.

Reset
REQ-025 SHALL, on rst=1 at any edge including mid-RUN or mid-SIGN, enter IDLE and set busy=0, done=0, div_by_zero=0, hi=0, lo=0; any in-flight op is discarded.
REQ-026 SHALL give rst priority over start, mthi and mtlo in the same cycle.

Structure
REQ-027 SHALL place the op encodings and the FSM state encoding in shared package muldiv_pkg.
REQ-028 SHALL be a single module with no sub-module; the datapath is one 64-bit shift register plus a 33-bit adder/subtractor shared by multiply and divide.

Verification
REQ-029 SHALL check MULT a=7, b=0xFFFFFFFD -> after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse of 1 cycle.
REQ-030 SHALL check MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 SHALL check DIV a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 SHALL check mthi 0x1234 then DIVU a=100, b=0 -> div_by_zero=1 with done, hi=0x1234 unchanged.
REQ-033 SHALL check start MULTU 3*5, assert rst at cycle 10 of RUN -> next cycle busy=0, hi=lo=0, no done pulse; a fresh start after reset gives lo=15.
REQ-034 SHALL check a second start and mtlo 0xAA during busy are ignored: the result reflects the first op and lo is not 0xAA.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op and state encodings for the multiply/divide unit
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SIGN = 2'd2
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with architectural HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mthi,
    input  logic         mtlo,
    input  logic [W-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         div_by_zero
);

    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_e          r_state;
    state_e          w_next;
    logic [2*W-1:0]  r_acc;
    logic [W-1:0]    r_opd;
    logic [CW-1:0]   r_cnt;
    logic            r_is_div;
    logic            r_neg_lo;
    logic            r_neg_hi;
    logic            r_dbz;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic            r_done;
    logic            r_dbz_out;

    op_e             w_op;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;
    logic [W:0]      w_add_a;
    logic [W:0]      w_add_b;
    logic [W+1:0]    w_sum;
    logic [2*W-1:0]  w_acc_step;
    logic [2*W-1:0]  w_prod;
    logic [W-1:0]    w_res_hi;
    logic [W-1:0]    w_res_lo;

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz_out;
    assign hi          = r_hi;
    assign lo          = r_lo;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_next = S_SIGN;
            S_SIGN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Both ops iterate on magnitudes; signs are reapplied in SIGN.
    always_comb begin
        w_op    = op_e'(op);
        w_a_neg = op_is_signed(w_op) & a[W-1];
        w_b_neg = op_is_signed(w_op) & b[W-1];
        w_a_mag = w_a_neg ? -a : a;
        w_b_mag = w_b_neg ? -b : b;
    end

    // Shared adder: add for multiply, subtract with carry-out as no-borrow for divide.
    always_comb begin
        w_add_a = r_is_div ? r_acc[2*W-1:W-1] : {1'b0, r_acc[2*W-1:W]};
        w_add_b = r_is_div ? ~{1'b0, r_opd} : {1'b0, r_opd};
        w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(W+1){1'b0}}, r_is_div};
    end

    always_comb begin
        w_acc_step = r_acc;
        if (r_is_div) begin
            if (w_sum[W+1]) w_acc_step = {w_sum[W-1:0], r_acc[W-2:0], 1'b1};
            else            w_acc_step = {r_acc[2*W-2:0], 1'b0};
        end else begin
            if (r_acc[0])   w_acc_step = {w_sum[W:0], r_acc[W-1:1]};
            else            w_acc_step = {1'b0, r_acc[2*W-1:1]};
        end
    end

    always_comb begin
        w_prod   = r_neg_lo ? -r_acc : r_acc;
        w_res_hi = w_prod[2*W-1:W];
        w_res_lo = w_prod[W-1:0];
        if (r_is_div) begin
            w_res_lo = r_neg_lo ? -r_acc[W-1:0] : r_acc[W-1:0];
            w_res_hi = r_neg_hi ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_opd    <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc    <= {{W{1'b0}}, w_a_mag};
                        r_opd    <= w_b_mag;
                        r_cnt    <= '0;
                        r_is_div <= op_is_div(w_op);
                        r_neg_lo <= w_a_neg ^ w_b_neg;
                        r_neg_hi <= w_a_neg;
                        r_dbz    <= op_is_div(w_op) && (b == '0);
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Direct writes are only possible in IDLE, so they never collide with a completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
            if (r_state == S_SIGN) begin
                r_done    <= 1'b1;
                r_dbz_out <= r_dbz;
                if (!r_dbz) begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
            end else if (r_state == S_IDLE) begin
                if (mthi) r_hi <= wdata;
                if (mtlo) r_lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit with directed vectors
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    muldiv_unit #(.W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    vec_t vt [0:9] = '{
        '{2'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB},
        '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
        '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
        '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
        '{2'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E},
        '{2'd2, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2},
        '{2'd0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E},
        '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
        '{2'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF},
        '{2'd2, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2}
    };

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: actual done=1 at cycle %0d required no pulse", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.nm, "_hi"}, hi, e.hi);
                chk({e.nm, "_lo"}, lo, e.lo);
                chk({e.nm, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
                chk({e.nm, "_latency"}, cyc, e.cyc);
                chk({e.nm, "_busy_at_done"}, 32'(busy), 0);
                chk({e.nm, "_done_width"}, 32'(prev_done), 0);
            end
        end
        prev_done = done;
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic mt_lo, input logic [31:0] wd);
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1; mtlo = mt_lo; wdata = wd;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        chk("start_busy", 32'(busy), 1);
    endtask

    task automatic expect_res(input string nm, input logic [31:0] eh, input logic [31:0] el,
                              input logic ed);
        exp_t e;
        e.nm = nm; e.hi = eh; e.lo = el; e.dbz = ed; e.cyc = cyc + 33;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: actual %0d results pending required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual simulation still running required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m_hi;
        logic [31:0] m_lo;

        // reset wins over start and direct writes
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hFFFF0000; start = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dbz", 32'(div_by_zero), 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        @(negedge clk);
        chk("rst_no_start", 32'(busy), 0);

        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both_hi", hi, 32'hDEADBEEF);
        chk("mt_both_lo", lo, 32'hDEADBEEF);

        for (int i = 0; i < 10; i++) begin
            launch(vt[i].op, vt[i].a, vt[i].b, 1'b0, 32'h0);
            expect_res($sformatf("vec%0d", i), vt[i].eh, vt[i].el, 1'b0);
            drain();
        end
        m_hi = 32'hFFFFFFFE;
        m_lo = 32'hFFFFFFF2;

        @(negedge clk);
        mthi = 1'b1; wdata = 32'h00001234;
        @(negedge clk);
        mthi = 1'b0;
        m_hi = 32'h00001234;
        chk("mthi_hi", hi, m_hi);
        chk("mthi_lo_kept", lo, m_lo);

        launch(2'd3, 32'd100, 32'd0, 1'b0, 32'h0);
        expect_res("divu_zero", m_hi, m_lo, 1'b1);
        drain();
        launch(2'd2, 32'hFFFFFFFB, 32'd0, 1'b0, 32'h0);
        expect_res("div_zero", m_hi, m_lo, 1'b1);
        drain();

        launch(2'd1, 32'd6, 32'd7, 1'b1, 32'h00000055);
        chk("start_mtlo_lo", lo, 32'h00000055);
        expect_res("multu_6x7", 32'h0, 32'h0000002A, 1'b0);
        drain();

        launch(2'd1, 32'd9, 32'd9, 1'b0, 32'h0);
        expect_res("busy_ignore", 32'h0, 32'h00000051, 1'b0);
        repeat (3) @(negedge clk);
        op = 2'd3; a = 32'd1000; b = 32'd3; start = 1'b1;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h000000AA;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("busy_mthi_ignored", hi, 32'h0);
        chk("busy_mtlo_ignored", lo, 32'h0000002A);
        drain();
        chk("busy_no_second_op", 32'(busy), 0);

        launch(2'd1, 32'd3, 32'd5, 1'b0, 32'h0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_busy", 32'(busy), 0);
        chk("midrun_rst_hi", hi, 0);
        chk("midrun_rst_lo", lo, 0);
        repeat (40) @(negedge clk);
        chk("midrun_rst_idle", 32'(busy), 0);

        launch(2'd1, 32'd3, 32'd5, 1'b0, 32'h0);
        expect_res("after_rst_multu", 32'h0, 32'h0000000F, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
